// File: rtl/wallace_mult_arbiter.sv
// Shares one combinational 4x4 Wallace/CLA multiplier among NREQ requesters with a registered, ID-tagged response.
// WALLACE_ARB_RR_EN selects round-robin arbitration; when it is undefined, fixed priority applies (lowest index wins).
module wallace_mult_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_product,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] last_grant_reg, last_grant_next;
  logic [3:0]     op_a_reg, op_b_reg;
  logic [IDW-1:0] id_reg;
  logic [7:0]     rsp_product_reg;
  logic [IDW-1:0] rsp_id_reg;

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] idx_sel;
  int             idx;
  logic           accept;
  logic [3:0]     sel_a, sel_b;

  // Arbiter: the first valid requester in search order wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef WALLACE_ARB_RR_EN
      idx = (int'(last_grant_reg) + 1 + k) % NREQ;
`else
      idx = k;
`endif
      idx_sel = IDW'(idx);
      if (!grant_any && req_valid[idx_sel]) begin
        grant_any = 1'b1;
        grant_idx = idx_sel;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        sel_a = req_a[4*k +: 4];
        sel_b = req_b[4*k +: 4];
      end
    end
  end

  // Next-state logic; a grant is only possible from IDLE or on the response handshake.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (grant_any) begin
            accept     = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last_grant_next = accept ? grant_idx : last_grant_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Multiplier: partial products, two carry-save levels, then a carry-lookahead adder.
  logic [7:0] pp [4];
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      assign pp[gi] = {4'b0000, op_a_reg & {4{op_b_reg[gi]}}} << gi;
    end
  endgenerate

  logic [7:0] csa1_s, csa1_c, csa2_s, csa2_c;
  assign csa1_s = pp[0] ^ pp[1] ^ pp[2];
  assign csa1_c = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
  assign csa2_s = csa1_s ^ csa1_c ^ pp[3];
  assign csa2_c = ((csa1_s & csa1_c) | (csa1_s & pp[3]) | (csa1_c & pp[3])) << 1;

  logic [6:0] cla_g;
  logic [7:0] cla_p;
  logic [7:0] cla_carry;
  logic       cla_term;
  logic [7:0] mult_product;

  assign cla_g = csa2_s[6:0] & csa2_c[6:0];
  assign cla_p = csa2_s ^ csa2_c;

  // Every carry is an explicit generate/propagate sum-of-products; there is no rippling.
  always_comb begin
    cla_carry = '0;
    cla_term  = 1'b0;
    for (int i = 1; i < 8; i++) begin
      for (int j = 0; j < i; j++) begin
        cla_term = cla_g[j];
        for (int k = j + 1; k < i; k++) begin
          cla_term = cla_term & cla_p[k];
        end
        cla_carry[i] = cla_carry[i] | cla_term;
      end
    end
  end

  assign mult_product = cla_p ^ cla_carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      last_grant_reg  <= IDW'(NREQ - 1);
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      id_reg          <= '0;
      rsp_product_reg <= '0;
      rsp_id_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      if (accept) begin
        op_a_reg <= sel_a;
        op_b_reg <= sel_b;
        id_reg   <= grant_idx;
      end
      if (state_reg == EXEC) begin
        rsp_product_reg <= mult_product;
        rsp_id_reg      <= id_reg;
      end
    end
  end

  assign rsp_valid   = (state_reg == RESP);
  assign rsp_product = rsp_product_reg;
  assign rsp_id      = rsp_id_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Self-checking bench for wallace_mult_arbiter: a cycle-level reference model plus a scoreboard of expected responses.
// Whether arbitration is round-robin or fixed priority follows WALLACE_ARB_RR_EN, as in the design.
module tb_wallace_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef WALLACE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_product;
  logic              busy;

  wallace_mult_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int a; int b; int prod; } exp_t;
  typedef struct { int id; int a; int b; int prod; } vec_t;

  exp_t sb[$];
  int   dut_grants[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   m_state = 0;       // 0 idle, 1 exec, 2 resp
  int   m_last  = NREQ - 1;
  bit   accepted;
  int   last_rsp_prod, last_rsp_id;
  vec_t tbl [8];

  task automatic chk(string name, int act, int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_expired(string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic int arb(logic [NREQ-1:0] v, int last);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = RR ? (last + 1 + k) % NREQ : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock of checking: compare at negedge against the model, then advance the model.
  task automatic cycle();
    int   w;
    bit   can;
    int   mask;
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    can  = (m_state == 0) || (m_state == 2 && rsp_ready);
    w    = arb(req_valid, m_last);
    mask = (can && w >= 0) ? (1 << w) : 0;
    chk("req_ready", int'(req_ready), mask);
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) dut_grants.push_back(k);
    chk("rsp_valid", int'(rsp_valid), (m_state == 2) ? 1 : 0);
    chk("busy", int'(busy), (m_state != 0) ? 1 : 0);
    if (m_state == 2 && sb.size() > 0) begin
      chk("rsp_id", int'(rsp_id), sb[0].id);
      chk("rsp_product", int'(rsp_product), sb[0].prod);
      if (rsp_ready) begin
        last_rsp_prod = int'(rsp_product);
        last_rsp_id   = int'(rsp_id);
        $display("rsp id=%0d a=%0d b=%0d product=%0d", rsp_id, sb[0].a, sb[0].b, rsp_product);
        void'(sb.pop_front());
      end
    end
    if (mask != 0) begin
      e.id   = w;
      e.a    = int'(req_a[4*w +: 4]);
      e.b    = int'(req_b[4*w +: 4]);
      e.prod = e.a * e.b;
      sb.push_back(e);
      m_last   = w;
      accepted = 1'b1;
    end
    case (m_state)
      0: m_state = (mask != 0) ? 1 : 0;
      1: m_state = 2;
      default: if (rsp_ready) m_state = (mask != 0) ? 1 : 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_product", int'(rsp_product), 0);
    chk("reset rsp_id", int'(rsp_id), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset req_ready", int'(req_ready), 0);
    sb.delete();
    m_state = 0;
    m_last  = NREQ - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(int i, int a, int b);
    req_valid[i]     = 1'b1;
    req_a[4*i +: 4]  = 4'(a);
    req_b[4*i +: 4]  = 4'(b);
  endtask

  task automatic wait_accept(string name);
    for (int n = 0; n < 16; n++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) bound_expired(name);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (sb.size() == 0 && m_state == 0) break;
      cycle();
    end
    if (sb.size() != 0) bound_expired("drain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tbl[0] = '{0, 15, 15, 225};
    tbl[1] = '{1,  0,  0,   0};
    tbl[2] = '{2,  1,  1,   1};
    tbl[3] = '{3, 15,  1,  15};
    tbl[4] = '{1,  9,  7,  63};
    tbl[5] = '{2, 12, 10, 120};
    tbl[6] = '{0,  8,  8,  64};
    tbl[7] = '{3,  7, 13,  91};

    do_reset();

    // Single-requester transactions against hand-computed products
    for (int i = 0; i < 8; i++) begin
      set_req(tbl[i].id, tbl[i].a, tbl[i].b);
      wait_accept("tbl accept");
      req_valid = '0;
      drain();
      chk("tbl product", last_rsp_prod, tbl[i].prod);
      chk("tbl id", last_rsp_id, tbl[i].id);
    end

    // All requesters pending continuously
    dut_grants.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 3);
    repeat (10) cycle();
    req_valid = '0;
    drain();
    if (dut_grants.size() < 5) bound_expired("burst grants");
    else begin
      for (int i = 0; i < 5; i++) chk("burst grant order", dut_grants[i], RR ? (i % NREQ) : 0);
    end

    // Backpressure with requester 2 pending
    dut_grants.delete();
    set_req(2, 5, 6);
    rsp_ready = 1'b0;
    wait_accept("bp accept");
    set_req(2, 3, 4);
    cycle();
    repeat (5) cycle();
    chk("bp held product", int'(rsp_product), 30);
    chk("bp held id", int'(rsp_id), 2);
    rsp_ready = 1'b1;
    cycle();
    chk("bp same-cycle grant", (dut_grants.size() == 2) ? dut_grants[1] : -1, 2);
    req_valid = '0;
    drain();
    chk("bp second product", last_rsp_prod, 12);

    // Reset while 9*7 is in EXEC
    set_req(2, 9, 7);
    wait_accept("rst accept");
    req_valid = '0;
    do_reset();
    repeat (4) cycle();
    dut_grants.delete();
    set_req(1, 2, 2);
    set_req(3, 3, 3);
    wait_accept("post-reset accept");
    chk("post-reset first grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 1);
    req_valid = '0;
    drain();

    // Every A/B pair from a random requester, with random response backpressure
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        set_req(int'($urandom_range(0, NREQ - 1)), a, b);
        accepted = 1'b0;
        for (int n = 0; n < 40; n++) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          cycle();
          if (accepted) break;
        end
        if (!accepted) bound_expired("exhaustive accept");
        req_valid = '0;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
